div_port_sequencer: RTL and testbench

Upstream driver for the memory-mapped x/y divider peripheral. Accepts 16-bit operand pairs on a valid/ready handshake and runs the divider's port protocol: write x to address 0, write y to address 1, read the quotient from address 2. Returns the quotient on a second valid/ready handshake. Short-circuits divide-by-zero so the divider never sees y = 0.

---
 rtl/div_seq_pkg.sv | 23 ++
 rtl/div_port_sequencer.sv | 123 ++++++++++++
 tb/tb_div_port_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// Shared definitions for the divider port sequencer and the divider peripheral.
package div_seq_pkg;

    localparam int unsigned DATA_W = 16;

    // Divider register map; the peripheral decodes the same constants.
    localparam logic [1:0] ADDR_X = 2'd0;
    localparam logic [1:0] ADDR_Y = 2'd1;
    localparam logic [1:0] ADDR_Q = 2'd2;

    // Quotient reported when the divisor is zero.
    localparam logic [DATA_W-1:0] DZ_QUOT_DEFAULT = {DATA_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WX,
        ST_WY,
        ST_RD,
        ST_CAP,
        ST_RESP
    } seq_state_e;

endpackage

// File: rtl/div_port_sequencer.sv
// Drives the memory-mapped x/y divider: write x, write y, read quotient,
// and returns the result on a valid/ready handshake. Divide-by-zero is
// answered locally so the divider never sees a zero divisor.
module div_port_sequencer
    import div_seq_pkg::*;
#(
    parameter int unsigned     W       = DATA_W,
    parameter logic [W-1:0]    DZ_QUOT = {W{1'b1}}
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_q,
    output logic         res_dz,
    output logic         res_err,
    output logic [W-1:0] DIV_D,
    output logic [1:0]   DIV_ADDR,
    output logic         DIV_W,
    output logic         DIV_R,
    output logic         DIV_E,
    input  logic [31:0]  DIV_OUT
);

    seq_state_e   state_q;
    logic [W-1:0] x_q;
    logic [W-1:0] y_q;
    logic [W-1:0] res_q_q;
    logic         res_valid_q;
    logic         res_dz_q;
    logic         res_err_q;

    // Only one operation in flight; accept only from IDLE and never during reset.
    assign in_ready  = (state_q == ST_IDLE) && !RST;

    assign res_valid = res_valid_q;
    assign res_q     = res_q_q;
    assign res_dz    = res_dz_q;
    assign res_err   = res_err_q;

    // Sequencer FSM with operand and result registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            res_q_q     <= '0;
            res_valid_q <= 1'b0;
            res_dz_q    <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_q <= in_x;
                        y_q <= in_y;
                        if (in_y == '0) begin
                            res_q_q     <= DZ_QUOT;
                            res_dz_q    <= 1'b1;
                            res_err_q   <= 1'b0;
                            res_valid_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end else begin
                            state_q <= ST_WX;
                        end
                    end
                end
                ST_WX:  state_q <= ST_WY;
                ST_WY:  state_q <= ST_RD;
                ST_RD:  state_q <= ST_CAP;
                ST_CAP: begin
                    // Divider read data is registered by the end of RD.
                    res_q_q     <= DIV_OUT[W-1:0];
                    res_err_q   <= |DIV_OUT[31:W];
                    res_dz_q    <= 1'b0;
                    res_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Divider port decode, from the registered state only.
    always_comb begin
        DIV_D    = '0;
        DIV_ADDR = ADDR_X;
        DIV_W    = 1'b0;
        DIV_R    = 1'b0;
        DIV_E    = 1'b0;
        case (state_q)
            ST_WX: begin
                DIV_D    = x_q;
                DIV_ADDR = ADDR_X;
                DIV_W    = 1'b1;
                DIV_E    = 1'b1;
            end
            ST_WY: begin
                DIV_D    = y_q;
                DIV_ADDR = ADDR_Y;
                DIV_W    = 1'b1;
                DIV_E    = 1'b1;
            end
            ST_RD: begin
                DIV_ADDR = ADDR_Q;
                DIV_R    = 1'b1;
                DIV_E    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_div_port_sequencer.sv
// Directed bench for div_port_sequencer with a behavioural divider model.
module tb_div_port_sequencer;
    import div_seq_pkg::*;

    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_y;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_q;
    logic        res_dz;
    logic        res_err;
    logic [15:0] DIV_D;
    logic [1:0]  DIV_ADDR;
    logic        DIV_W;
    logic        DIV_R;
    logic        DIV_E;
    logic [31:0] DIV_OUT;

    int errors = 0;
    int checks = 0;

    div_port_sequencer #(.W(16), .DZ_QUOT(16'hFFFF)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .res_valid(res_valid), .res_ready(res_ready), .res_q(res_q),
        .res_dz(res_dz), .res_err(res_err),
        .DIV_D(DIV_D), .DIV_ADDR(DIV_ADDR), .DIV_W(DIV_W), .DIV_R(DIV_R),
        .DIV_E(DIV_E), .DIV_OUT(DIV_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Divider peripheral model: registered writes, registered read data.
    logic [15:0] mx, my;
    logic        force_en;
    logic [31:0] force_val;
    logic [4:0]  strobe_log[$];
    int          strobe_cnt;

    initial begin
        mx = '0; my = '0; DIV_OUT = '0; strobe_cnt = 0;
    end

    always @(posedge CLK) begin
        if (DIV_W || DIV_R || DIV_E) strobe_cnt = strobe_cnt + 1;
        if (DIV_E) strobe_log.push_back({DIV_ADDR, DIV_W, DIV_R, 1'b1});
        if (DIV_E && DIV_W && DIV_ADDR == ADDR_X) mx <= DIV_D;
        if (DIV_E && DIV_W && DIV_ADDR == ADDR_Y) my <= DIV_D;
        if (DIV_E && DIV_R && DIV_ADDR == ADDR_Q)
            DIV_OUT <= force_en ? force_val : {16'h0, (my == 16'h0) ? 16'hFFFF : mx / my};
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one pair for a single cycle; caller guarantees the DUT is in IDLE.
    task automatic accept(input logic [15:0] x, input logic [15:0] y);
        in_x = x; in_y = y; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (!res_valid && n < 12) begin
            tick();
            n++;
        end
        if (!res_valid) check({tag, "_timeout"}, 32'(res_valid), 32'd1);
    endtask

    int          acc_edges[$];
    logic [15:0] qs[$];
    int          edge_n;
    bit          acc;
    int          snap;

    initial begin
        RST = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; res_ready = 1'b0;
        force_en = 1'b0; force_val = '0;
        tick(); tick();

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_q", 32'(res_q), 32'd0);
        check("rst_div", {DIV_D, DIV_ADDR, DIV_W, DIV_R, DIV_E}, 32'd0);
        RST = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // 4/2 with latency and strobe order
        strobe_log.delete();
        accept(16'd4, 16'd2);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("lat_edge%0d_res_valid", i), 32'(res_valid), 32'd0);
        end
        tick();
        check("lat_edge4_res_valid", 32'(res_valid), 32'd1);
        check("q_4_2", 32'(res_q), 32'd2);
        check("dz_4_2", 32'(res_dz), 32'd0);
        check("err_4_2", 32'(res_err), 32'd0);
        check("strobe_count", 32'(strobe_log.size()), 32'd3);
        check("strobe0", (strobe_log.size() > 0) ? 32'(strobe_log[0]) : 32'hDEAD, 32'({2'd0, 1'b1, 1'b0, 1'b1}));
        check("strobe1", (strobe_log.size() > 1) ? 32'(strobe_log[1]) : 32'hDEAD, 32'({2'd1, 1'b1, 1'b0, 1'b1}));
        check("strobe2", (strobe_log.size() > 2) ? 32'(strobe_log[2]) : 32'hDEAD, 32'({2'd2, 1'b0, 1'b1, 1'b1}));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("idle_after_4_2", 32'(in_ready), 32'd1);

        // Back-to-back with res_ready high
        res_ready = 1'b1;
        in_x = 16'd100; in_y = 16'd1; in_valid = 1'b1;
        edge_n = 0;
        for (int i = 0; i < 30 && qs.size() < 2; i++) begin
            acc = in_valid && in_ready;
            tick();
            edge_n++;
            if (acc) begin
                acc_edges.push_back(edge_n);
                if (acc_edges.size() == 1) begin
                    in_x = 16'd65535; in_y = 16'd65535;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (res_valid) qs.push_back(res_q);
        end
        in_valid = 1'b0;
        tick();
        res_ready = 1'b0;
        check("b2b_results", 32'(qs.size()), 32'd2);
        check("b2b_q0", (qs.size() > 0) ? 32'(qs[0]) : 32'hDEAD, 32'd100);
        check("b2b_q1", (qs.size() > 1) ? 32'(qs[1]) : 32'hDEAD, 32'd1);
        check("b2b_spacing", (acc_edges.size() > 1) ? 32'(acc_edges[1] - acc_edges[0]) : 32'hDEAD, 32'd6);

        // Divide by zero
        snap = strobe_cnt;
        accept(16'd7, 16'd0);
        check("dz_res_valid", 32'(res_valid), 32'd1);
        check("dz_res_q", 32'(res_q), 32'hFFFF);
        check("dz_flag", 32'(res_dz), 32'd1);
        check("dz_err", 32'(res_err), 32'd0);
        check("dz_in_ready", 32'(in_ready), 32'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("dz_done", 32'(res_valid), 32'd0);
        check("dz_no_strobes", 32'(strobe_cnt - snap), 32'd0);

        // Backpressure 9/3
        accept(16'd9, 16'd3);
        wait_result("bp");
        check("bp_q", 32'(res_q), 32'd3);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_x = 16'd50; in_y = 16'd5;
            tick();
            check("bp_hold_valid", 32'(res_valid), 32'd1);
            check("bp_hold_q", 32'(res_q), 32'd3);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        check("bp_y_not_resampled", 32'(dut.y_q), 32'd3);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("bp_released", 32'(res_valid), 32'd0);
        check("bp_idle", 32'(in_ready), 32'd1);

        // Reset while in WY
        accept(16'd20, 16'd5);
        tick();
        check("wy_reached", {DIV_ADDR, DIV_W, DIV_E}, 32'({2'd1, 1'b1, 1'b1}));
        RST = 1'b1;
        tick();
        check("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("mid_rst_div", {DIV_D, DIV_ADDR, DIV_W, DIV_R, DIV_E}, 32'd0);
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mid_rst_no_result", 32'(res_valid), 32'd0);
        end
        accept(16'd8, 16'd4);
        wait_result("after_rst");
        check("after_rst_q", 32'(res_q), 32'd2);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Upper divider bits flag an error
        force_en = 1'b1; force_val = 32'h0001_0005;
        accept(16'd10, 16'd2);
        wait_result("err");
        check("err_q", 32'(res_q), 32'd5);
        check("err_flag", 32'(res_err), 32'd1);
        check("err_dz", 32'(res_dz), 32'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        force_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
